// File: rtl/sub_unit_pkg.sv
// sub_unit_pkg: shared constants, result record and helpers for sub_unit_stream.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   FIFO_DEPTH / PTR_W / CNT_FW  - output buffer geometry (3 entries, 2-bit pointers)
//   sub_rec_t                    - {diff, borrow, ovf} record at the reference 32-bit width
//   sat_max / sat_min            - saturation bounds for a given operand width
//   ptr_inc                      - buffer pointer increment with 2 -> 0 wrap
package sub_unit_pkg;

  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned PTR_W      = 2;
  // Occupancy counter must represent 0..FIFO_DEPTH inclusive.
  localparam int unsigned CNT_FW     = 2;
  localparam int unsigned REC_DATA_W = 32;
  // Widest operand the saturation helpers support.
  localparam int unsigned MAX_W      = 64;

  typedef struct packed {
    logic [REC_DATA_W-1:0] diff;
    logic                  borrow;
    logic                  ovf;
  } sub_rec_t;

  // Largest positive two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(int unsigned w);
    logic [MAX_W-1:0] v;
    v = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    return v;
  endfunction

  // Most negative two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_min(int unsigned w);
    logic [MAX_W-1:0] v;
    v = MAX_W'(1) << (w - 1);
    return v;
  endfunction

  // Pointers walk 0,1,2,0,... ; value 3 is never produced.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/sub_unit_stream_if.sv
// sub_unit_stream_if: operand/result stream bundle for sub_unit_stream.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on results.
//
// Signals:
//   in_valid, in_ready, sub_a, sub_b              - operand side
//   out_valid, out_ready, sub_out, out_borrow, out_ovf - result side
// Modports: master = producer/consumer around the block, slave = the block itself.
interface sub_unit_stream_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sub_a;
  logic [DATA_W-1:0] sub_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sub_out;
  logic              out_borrow;
  logic              out_ovf;

  modport master (
    output in_valid,
    output sub_a,
    output sub_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sub_out,
    input  out_borrow,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  sub_a,
    input  sub_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sub_out,
    output out_borrow,
    output out_ovf
  );

endinterface

// File: rtl/sub_out_fifo.sv
// sub_out_fifo: 3-entry synchronous FIFO holding subtraction result records.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: caller guarantees space on push; pop on empty is ignored.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (clears pointers and count)
//   push, push_rec  - write a record at the tail
//   pop             - drop the head record
//   head            - current head record (undefined content when cnt == 0)
//   cnt             - occupancy 0..3
module sub_out_fifo
  import sub_unit_pkg::*;
#(
  parameter type rec_t = sub_rec_t
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  rec_t              push_rec,
  input  logic              pop,
  output rec_t              head,
  output logic [CNT_FW-1:0] cnt
);

  rec_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count untouched.
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_FW'(1);
        2'b01:   cnt <= cnt - CNT_FW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset: contents are only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sub_unit_stream.sv
// sub_unit_stream: streaming subtractor sub_a - sub_b with borrow and signed-overflow flags.
// Latency: 2 cycles (stage-1 register, then 3-entry output buffer); 1 result/cycle sustained.
// Backpressure: in_ready comes from registers only; it drops once 3 results are in flight.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (in_ready forced low while asserted)
//   bus          - sub_unit_stream_if.slave: operand and result valid/ready streams
//   clr_cnt      - synchronous clear of op_cnt, wins over a same-cycle transfer
//   op_cnt       - count of completed output transfers, wraps at 2^CNT_W
// Build option: define SUB_UNIT_SAT_EN to saturate sub_out on signed overflow
// (out_ovf still reports the overflow); otherwise sub_out is the wrapped difference.
module sub_unit_stream
  import sub_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_unit_stream_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] diff;
    logic              borrow;
    logic              ovf;
  } rec_t;

  localparam int MSB = DATA_W - 1;

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W:0]   diff_ext;
  logic              ovf_c;
  rec_t              s1_nxt;
  rec_t              s1_rec;
  rec_t              head;
  logic              s1_v;
  logic [CNT_FW-1:0] fifo_cnt;
  logic [2:0]        occ;

  // ---------------------------------------------------------------------------
  // Input acceptance. Counting the stage-1 slot together with the buffer
  // guarantees that whatever is accepted always has a buffer entry waiting for
  // it, so stage 1 never has to stall and in_ready needs no look at out_ready.
  // ---------------------------------------------------------------------------
  assign occ          = 3'(s1_v) + 3'(fifo_cnt);
  assign bus.in_ready = rst_n && (occ < 3'(FIFO_DEPTH));
  assign in_fire      = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 arithmetic. The extra top bit of the zero-extended difference is
  // the unsigned borrow; signed overflow is only possible when the operand
  // signs differ and the result sign departs from the minuend's.
  // ---------------------------------------------------------------------------
  assign diff_ext = {1'b0, bus.sub_a} - {1'b0, bus.sub_b};
  assign ovf_c    = (bus.sub_a[MSB] != bus.sub_b[MSB]) &&
                    (diff_ext[MSB] != bus.sub_a[MSB]);

`ifdef SUB_UNIT_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX_V = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SAT_MIN_V = DATA_W'(sat_min(DATA_W));

  // Overflow direction follows the minuend's sign, so the clamp value is
  // picked from sub_a alone and only applied when overflow is flagged.
  logic [DATA_W-1:0] sat_val;
  assign sat_val = bus.sub_a[MSB] ? SAT_MIN_V : SAT_MAX_V;
`endif

  always_comb begin
    s1_nxt        = '0;
    s1_nxt.borrow = diff_ext[DATA_W];
    s1_nxt.ovf    = ovf_c;
`ifdef SUB_UNIT_SAT_EN
    s1_nxt.diff   = ovf_c ? sat_val : diff_ext[MSB:0];
`else
    s1_nxt.diff   = diff_ext[MSB:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_rec <= '0;
    end else begin
      s1_v <= in_fire;
      if (in_fire) begin
        s1_rec <= s1_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output buffer. A valid stage-1 record is pushed unconditionally.
  // ---------------------------------------------------------------------------
  sub_out_fifo #(
    .rec_t (rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s1_v),
    .push_rec (s1_rec),
    .pop      (out_fire),
    .head     (head),
    .cnt      (fifo_cnt)
  );

  assign bus.out_valid = (fifo_cnt != '0);
  assign out_fire      = bus.out_valid && bus.out_ready;

  // Result fields read as zero whenever nothing is buffered (including reset).
  assign bus.sub_out    = bus.out_valid ? head.diff   : '0;
  assign bus.out_borrow = bus.out_valid && head.borrow;
  assign bus.out_ovf    = bus.out_valid && head.ovf;

  // ---------------------------------------------------------------------------
  // Completed-transfer counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (clr_cnt) begin
      op_cnt <= '0;
    end else if (out_fire) begin
      op_cnt <= op_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sub_unit_stream.sv
// tb_sub_unit_stream: self-checking bench for sub_unit_stream.
// Latency: n/a.
// Backpressure: exercised via out_ready patterns.
`timescale 1ns/1ps
module tb_sub_unit_stream;

  localparam int DW = 32;
  localparam int CW = 16;
`ifdef SUB_UNIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] op_cnt;

  always #5 clk = ~clk;

  sub_unit_stream_if #(.DATA_W(DW)) bus ();

  sub_unit_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .op_cnt  (op_cnt)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    logic          brw;
    logic          ovf;
  } vec_t;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW+1:0] sbq[$];
  logic [DW+1:0] next_exp;
  logic [CW-1:0] exp_cnt;
  bit            last_ifire, last_ofire;
  bit            hold_pend;
  logic [DW+1:0] held;
  bit            saw_nr;
  int            cyc = 0;
  int            n_out = 0;
  int            first_out_cyc, last_out_cyc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [DW+1:0] model(logic [DW-1:0] a, logic [DW-1:0] b);
    longint        sa, sb, d;
    logic          ovf, brw;
    logic [DW-1:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    d   = sa - sb;
    ovf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    brw = (a < b);
    r   = a - b;
    if (SAT && ovf) r = (d > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {r, brw, ovf};
  endfunction

  task automatic set_in(logic v, logic [DW-1:0] a, logic [DW-1:0] b);
    bus.in_valid = v;
    bus.sub_a    = a;
    bus.sub_b    = b;
    next_exp     = model(a, b);
  endtask

  // One clock: sample handshakes at negedge, score, then step past posedge.
  task automatic cycle();
    logic [DW+1:0] cur;
    @(negedge clk);
    cur        = {bus.sub_out, bus.out_borrow, bus.out_ovf};
    last_ifire = 1'b0;
    last_ofire = 1'b0;
    if (rst_n) begin
      last_ifire = bus.in_valid && bus.in_ready;
      last_ofire = bus.out_valid && bus.out_ready;
      if (!bus.in_ready) saw_nr = 1'b1;
      if (hold_pend && bus.out_valid) chk("hold_stable", cur, held);
      hold_pend = bus.out_valid && !bus.out_ready;
      held      = cur;
      if (last_ofire) begin
        chk("output_outstanding", sbq.size() != 0, 1);
        if (sbq.size() != 0) chk("result", cur, sbq.pop_front());
        n_out++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (last_ifire) sbq.push_back(next_exp);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n || clr_cnt) exp_cnt = '0;
    else if (last_ofire) exp_cnt = exp_cnt + 1'b1;
    if (!rst_n) begin
      sbq.delete();
      hold_pend = 1'b0;
    end
    chk("op_cnt", op_cnt, exp_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int   k, guard, n0, lat;

    bus.in_valid  = 1'b0;
    bus.sub_a     = '0;
    bus.sub_b     = '0;
    bus.out_ready = 1'b0;
    exp_cnt       = '0;
    hold_pend     = 1'b0;
    saw_nr        = 1'b0;
    first_out_cyc = -1;
    last_out_cyc  = -1;

    tv[0] = '{32'd10,        32'd3,         32'd7,                                1'b0, 1'b0};
    tv[1] = '{32'd3,         32'd10,        32'hFFFF_FFF9,                        1'b1, 1'b0};
    tv[2] = '{32'h8000_0000, 32'd1,         SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1};
    tv[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b1};
    tv[4] = '{32'h0,         32'h8000_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b1};
    tv[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,                                1'b0, 1'b0};
    tv[6] = '{32'h8000_0000, 32'h7FFF_FFFF, SAT ? 32'h8000_0000 : 32'h0000_0001, 1'b0, 1'b1};
    tv[7] = '{32'hFFFF_FFFE, 32'd5,         32'hFFFF_FFF9,                        1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs", {bus.sub_out, bus.out_borrow, bus.out_ovf}, 0);
    chk("rst_op_cnt", op_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Table vectors, one at a time, with latency and counter checks.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.sub_a    = tv[i].a;
      bus.sub_b    = tv[i].b;
      next_exp     = {tv[i].d, tv[i].brw, tv[i].ovf};
      cycle();
      chk("tbl_accept", last_ifire, 1);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 8) begin
        cycle();
        lat++;
      end
      chk("tbl_latency", lat, 2);
      cycle();
      chk("tbl_op_cnt", op_cnt, i + 1);
    end

    // Backpressure: 5 ops offered, only 3 fit while out_ready is low.
    bus.out_ready = 1'b0;
    k = 0;
    n0 = n_out;
    for (int c = 0; c < 8; c++) begin
      set_in(k < 5, k, 0);
      cycle();
      if (last_ifire) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_in_ready_after_pop", bus.in_ready, 1);
    guard = 0;
    while ((k < 5 || sbq.size() != 0) && guard < 30) begin
      set_in(k < 5, k, 0);
      cycle();
      if (last_ifire) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("bp_outputs", n_out - n0, 5);

    // Full throughput: 100 back-to-back ops.
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    saw_nr = 1'b0;
    first_out_cyc = -1;
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, $urandom, $urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (n_out - n0 < 100 && guard < 10) begin
      cycle();
      guard++;
    end
    chk("tp_in_ready_never_low", saw_nr, 0);
    chk("tp_outputs", n_out - n0, 100);
    chk("tp_span", last_out_cyc - first_out_cyc + 1, 100);
    chk("tp_op_cnt", op_cnt, 100);

    // Random traffic with corner operands, random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] ra, rb;
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h0000_0001;
        default: rb = $urandom;
      endcase
      set_in($urandom_range(0, 3) != 0, ra, rb);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clr_cnt       = 1'b0;
    guard = 0;
    while (sbq.size() != 0 && guard < 10) begin
      cycle();
      guard++;
    end
    chk("rand_drained", sbq.size(), 0);

    // Counter wrap: 0xFFFF transfers, then one more.
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      set_in(1'b1, i, ~i);
      cycle();
    end
    bus.in_valid = 1'b0;
    repeat (4) cycle();
    chk("cnt_ffff", op_cnt, 16'hFFFF);
    set_in(1'b1, 32'd100, 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    chk("cnt_wrap", op_cnt, 0);

    // Clear on the same cycle as a transfer.
    set_in(1'b1, 32'd20, 32'd5);
    cycle();
    set_in(1'b1, 32'd21, 32'd5);
    cycle();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 5) begin
      cycle();
      guard++;
    end
    cycle();
    chk("cnt_one", op_cnt, 1);
    chk("clr_xfer_valid", bus.out_valid, 1);
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("clr_over_xfer", op_cnt, 0);
    chk("clr_xfer_drained", sbq.size(), 0);

    // Mid-operation reset discards in-flight results.
    set_in(1'b1, 32'd9, 32'd4);
    cycle();
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_op_cnt", op_cnt, 1);
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'd50, 32'd1);
    cycle();
    set_in(1'b1, 32'd51, 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_op_cnt", op_cnt, 0);
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (6) cycle();
    chk("no_stale_output", n_out - n0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
